// File: rtl/dma_multichannel_controller.sv
// Multi-channel DMA: NUM_CH valid/ready source streams written through one memory write port
// under round-robin arbitration. Define DMA_CHANNEL_ABORT_EN to add a per-channel abort input.
module dma_multichannel_controller #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef DMA_CHANNEL_ABORT_EN
  input  logic [NUM_CH-1:0]            abort,
`endif
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH*ADDR_W-1:0]     start_address,
  input  logic [NUM_CH*(ADDR_W+1)-1:0] transfer_size,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            done,
  input  logic [NUM_CH-1:0]            src_valid,
  input  logic [NUM_CH*DATA_W-1:0]     src_data,
  output logic [NUM_CH-1:0]            src_ready,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic [DATA_W-1:0]            mem_wr_data,
  output logic [CH_W-1:0]              mem_wr_ch
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            st_q   [NUM_CH];
  state_e            st_d   [NUM_CH];
  logic [ADDR_W-1:0] addr_q [NUM_CH];
  logic [ADDR_W-1:0] addr_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];

  logic [CH_W-1:0]   ptr_q;
  logic [NUM_CH-1:0] abort_v;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] gnt_oh;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_idx;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [CH_W-1:0]   mem_ch_q;

`ifdef DMA_CHANNEL_ABORT_EN
  assign abort_v = abort;
`else
  assign abort_v = '0;
`endif

  // An aborting channel is never eligible, so abort wins over a grant in the same cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      busy[c]     = (st_q[c] == StBusy);
      done[c]     = (st_q[c] == StDone);
      eligible[c] = (st_q[c] == StBusy) && src_valid[c] && !abort_v[c] && !rst;
    end
  end

  // Search upward from the pointer with wrap; first eligible channel wins.
  always_comb begin
    logic [CH_W-1:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((32'(ptr_q) + i) % NUM_CH);
      if (!gnt_vld && eligible[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  assign src_ready = gnt_oh;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c]   = st_q[c];
      addr_d[c] = addr_q[c];
      cnt_d[c]  = cnt_q[c];
      if (st_q[c] == StBusy) begin
        if (abort_v[c]) begin
          st_d[c] = StIdle;
        end else if (gnt_oh[c]) begin
          addr_d[c] = addr_q[c] + 1'b1;
          cnt_d[c]  = cnt_q[c] - 1'b1;
          if (cnt_q[c] == CNT_W'(1)) begin
            st_d[c] = StDone;
          end
        end
      end else if (start[c]) begin
        // Zero-length requests complete without ever becoming busy.
        addr_d[c] = start_address[c*ADDR_W +: ADDR_W];
        cnt_d[c]  = transfer_size[c*CNT_W +: CNT_W];
        st_d[c]   = (transfer_size[c*CNT_W +: CNT_W] == '0) ? StDone : StBusy;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= StIdle;
        addr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      ptr_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_ch_q   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= st_d[c];
        addr_q[c] <= addr_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      mem_we_q <= gnt_vld;
      if (gnt_vld) begin
        ptr_q      <= CH_W'((32'(gnt_idx) + 1) % NUM_CH);
        mem_addr_q <= addr_q[gnt_idx];
        mem_data_q <= src_data[gnt_idx*DATA_W +: DATA_W];
        mem_ch_q   <= gnt_idx;
      end
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_wr_addr = mem_addr_q;
  assign mem_wr_data = mem_data_q;
  assign mem_wr_ch   = mem_ch_q;

endmodule

// File: tb/tb_dma_multichannel_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_dma_multichannel_controller;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CH_W   = 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int          AMOD   = 1 << ADDR_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        start;
  logic [NUM_CH*ADDR_W-1:0] start_address;
  logic [NUM_CH*CNT_W-1:0]  transfer_size;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        done;
  logic [NUM_CH-1:0]        src_valid;
  logic [NUM_CH*DATA_W-1:0] src_data;
  logic [NUM_CH-1:0]        src_ready;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_wr_addr;
  logic [DATA_W-1:0]        mem_wr_data;
  logic [CH_W-1:0]          mem_wr_ch;
  logic [NUM_CH-1:0]        abort;

  dma_multichannel_controller #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef DMA_CHANNEL_ABORT_EN
    .abort        (abort),
`endif
    .start        (start),
    .start_address(start_address),
    .transfer_size(transfer_size),
    .busy         (busy),
    .done         (done),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .mem_we       (mem_we),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ch    (mem_wr_ch)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 busy, 2 done; remaining words and next address per channel.
  int m_st [NUM_CH];
  int m_rem [NUM_CH];
  int m_addr [NUM_CH];
  int m_ptr, m_we, m_waddr, m_wdata, m_wch;

  int n_checks, n_fail;
  int log_addr [$];
  int log_data [$];
  int log_ch [$];
  logic [DATA_W-1:0] img [AMOD];
  int wrap_addr [4] = '{14, 15, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (m_ptr + k) % NUM_CH;
      if (m_st[c] == 1 && src_valid[c] && !abort[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_commit(input int g);
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_st[c] = 0; m_rem[c] = 0; m_addr[c] = 0;
      end
      m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_wch = 0;
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_st[c] == 1) begin
        if (abort[c]) m_st[c] = 0;
      end else if (start[c]) begin
        m_addr[c] = int'(start_address[c*ADDR_W +: ADDR_W]);
        m_rem[c]  = int'(transfer_size[c*CNT_W +: CNT_W]);
        m_st[c]   = (m_rem[c] == 0) ? 2 : 1;
      end
    end
    if (g >= 0) begin
      m_we = 1; m_waddr = m_addr[g]; m_wch = g;
      m_wdata = int'(src_data[g*DATA_W +: DATA_W]);
      m_addr[g] = (m_addr[g] + 1) % AMOD;
      m_rem[g]--;
      if (m_rem[g] == 0) m_st[g] = 2;
      m_ptr = (g + 1) % NUM_CH;
    end else begin
      m_we = 0;
    end
  endtask

  // One clock: check src_ready before the edge, advance the model, check registered outputs after.
  task automatic step();
    int g;
    logic [NUM_CH-1:0] exp_rdy, exp_busy, exp_done;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("src_ready", 32'(src_ready), 32'(exp_rdy));
    @(posedge clk);
    model_commit(g);
    #1;
    start = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_busy[c] = (m_st[c] == 1);
      exp_done[c] = (m_st[c] == 2);
    end
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("mem_we", 32'(mem_we), m_we);
    chk("mem_wr_addr", 32'(mem_wr_addr), m_waddr);
    chk("mem_wr_data", 32'(mem_wr_data), m_wdata);
    chk("mem_wr_ch", 32'(mem_wr_ch), m_wch);
    if (mem_we === 1'b1) begin
      log_addr.push_back(int'(mem_wr_addr));
      log_data.push_back(int'(mem_wr_data));
      log_ch.push_back(int'(mem_wr_ch));
      img[mem_wr_addr] = mem_wr_data;
    end
  endtask

  task automatic set_ch(input int c, input int addr, input int size);
    start_address[c*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    transfer_size[c*CNT_W +: CNT_W]   = CNT_W'(size);
  endtask

  task automatic set_data(input int c, input int d);
    src_data[c*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    log_ch.delete();
  endtask

  function automatic int count_ch(input int c);
    int n;
    n = 0;
    foreach (log_ch[i]) if (log_ch[i] == c) n++;
    return n;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = '0; abort = '0; src_valid = '0; src_data = '0;
    start_address = '0; transfer_size = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_st[c] = 0; m_rem[c] = 0; m_addr[c] = 0;
    end
    m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_wch = 0;
    step();
    step();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_mem_we", 32'(mem_we), 0);
    rst = 1'b0;

    // Single channel, full 16-word transfer.
    clear_logs();
    set_ch(0, 0, 16); start = 2'b01; step();
    for (int i = 0; i < 16; i++) begin
      src_valid = 2'b01; set_data(0, 8'h10 + i); step();
    end
    chk("t1_last_we", 32'(mem_we), 1);
    chk("t1_done0", 32'(done[0]), 1);
    chk("t1_busy0", 32'(busy[0]), 0);
    chk("t1_writes", log_addr.size(), 16);
    chk("t1_ch1_writes", count_ch(1), 0);
    for (int i = 0; i < 16; i++) chk("t1_mem", 32'(img[i]), 32'h10 + i);
    src_valid = '0;

    // Address wrap on channel 1.
    clear_logs();
    set_ch(1, 14, 4); start = 2'b10; step();
    for (int i = 0; i < 4; i++) begin
      src_valid = 2'b10; set_data(1, 8'hA0 + i); step();
    end
    chk("t2_writes", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("t2_addr", log_addr[i], wrap_addr[i]);
      chk("t2_data", log_data[i], 32'hA0 + i);
    end
    chk("t2_done1", 32'(done[1]), 1);
    src_valid = '0;

    // Contention: simultaneous starts alternate fairly.
    clear_logs();
    set_ch(0, 4, 3); set_ch(1, 8, 3); start = 2'b11; step();
    for (int i = 0; i < 6; i++) begin
      src_valid = 2'b11; src_data = 16'($urandom); step();
    end
    chk("t3_writes", log_ch.size(), 6);
    for (int i = 0; i < 6 && i < log_ch.size(); i++) chk("t3_ch_order", log_ch[i], i % 2);
    chk("t3_done", 32'(done), 32'h3);
    src_valid = '0;

    // Zero length, then start while busy is ignored.
    clear_logs();
    set_ch(0, 5, 0); start = 2'b01; step();
    chk("t4_zero_done", 32'(done[0]), 1);
    chk("t4_zero_we", 32'(mem_we), 0);
    set_ch(0, 2, 4); start = 2'b01; step();
    src_valid = 2'b01; step();
    set_ch(0, 9, 16); start = 2'b01; step();
    guard = 0;
    while (!done[0] && guard < 40) begin step(); guard++; end
    chk("t4_done", 32'(done[0]), 1);
    chk("t4_writes", log_addr.size(), 4);
    if (log_addr.size() == 4) chk("t4_last_addr", log_addr[3], 5);
    src_valid = '0;

    // Stalled source: exactly 8 writes.
    clear_logs();
    set_ch(0, 0, 8); start = 2'b01; step();
    guard = 0;
    while (!done[0] && guard < 200) begin
      src_valid = NUM_CH'($urandom_range(0, 1)); step(); guard++;
    end
    chk("t5_done", 32'(done[0]), 1);
    chk("t5_writes", log_addr.size(), 8);

    // Reset after the third write aborts everything; a fresh start then works.
    clear_logs();
    set_ch(0, 3, 8); start = 2'b01; step();
    guard = 0;
    src_valid = 2'b01;
    while (log_addr.size() < 3 && guard < 20) begin step(); guard++; end
    rst = 1'b1; step();
    chk("t6_rst_we", 32'(mem_we), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_addr", 32'(mem_wr_addr), 0);
    chk("t6_rst_data", 32'(mem_wr_data), 0);
    chk("t6_rst_ch", 32'(mem_wr_ch), 0);
    rst = 1'b0; step();
    chk("t6_no_more", log_addr.size(), 3);
    set_ch(0, 7, 2); start = 2'b01; step();
    step(); step();
    chk("t6_fresh_writes", log_addr.size(), 5);
    if (log_addr.size() == 5) chk("t6_fresh_addr", log_addr[4], 8);
    chk("t6_fresh_done", 32'(done[0]), 1);
    src_valid = '0;

`ifdef DMA_CHANNEL_ABORT_EN
    // Abort ch0 after 5 writes while ch1 keeps going.
    clear_logs();
    set_ch(0, 0, 10); set_ch(1, 0, 10); start = 2'b11; step();
    src_valid = 2'b11;
    guard = 0;
    while (count_ch(0) < 5 && guard < 40) begin step(); guard++; end
    abort = 2'b01; step(); abort = '0;
    chk("t7_busy0", 32'(busy[0]), 0);
    chk("t7_done0", 32'(done[0]), 0);
    guard = 0;
    while (!done[1] && guard < 40) begin step(); guard++; end
    chk("t7_ch0_writes", count_ch(0), 5);
    chk("t7_ch1_writes", count_ch(1), 10);
    chk("t7_done1", 32'(done[1]), 1);
    src_valid = '0;
`endif

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        start[c] = ($urandom_range(0, 7) == 0);
        set_ch(c, $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD));
`ifdef DMA_CHANNEL_ABORT_EN
        abort[c] = ($urandom_range(0, 29) == 0);
`endif
      end
      src_valid = NUM_CH'($urandom);
      src_data  = 16'($urandom);
      step();
    end
    rst = 1'b0; abort = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_multichannel_controller.md
Name: dma_multichannel_controller

Overview:
Multi-channel successor to the single-channel UART-to-memory DMA controller. Up to NUM_CH independent channels each move a programmed number of DATA_W words from their own valid/ready source stream into one shared memory write port. Sequential addresses wrap at 2^ADDR_W. A round-robin arbiter grants one source word per cycle, so the block sits between NUM_CH peripheral receivers and a single-write-port memory.

Parameters:
NUM_CH, 2, number of channels (1..8)
DATA_W, 8, data word width
ADDR_W, 4, memory address width; transfer length field is ADDR_W+1 bits, which allows a full 2^ADDR_W transfer

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  NUM_CH  per-channel start pulse
start_address  input  NUM_CH*ADDR_W  per-channel first write address; channel c at bits [c*ADDR_W +: ADDR_W]
transfer_size  input  NUM_CH*(ADDR_W+1)  per-channel word count; same packing
busy  output  NUM_CH  channel transfer in progress
done  output  NUM_CH  channel completed; level, held until next accepted start
src_valid  input  NUM_CH  source word available
src_data  input  NUM_CH*DATA_W  source words, packed like start_address
src_ready  output  NUM_CH  combinational one-hot; word consumed this cycle
mem_we  output  1  registered write strobe
mem_wr_addr  output  ADDR_W  registered write address
mem_wr_data  output  DATA_W  registered write data
mem_wr_ch  output  CH_W  channel that owns the current write; CH_W = max(1, clog2(NUM_CH))

Behaviour:
- Reset (rst=1 at an edge): busy, done, mem_we, mem_wr_addr, mem_wr_data and mem_wr_ch all become 0. The round-robin pointer returns to 0. src_ready=0 while rst=1. Reset mid-transfer aborts every channel, and no write occurs on the following cycle.
- Per-channel FSM: IDLE -> BUSY -> DONE.
  - IDLE/DONE + start[c]: latch the address and count. Clear done[c].
  - If size != 0: go to BUSY; busy[c]=1 from the next cycle.
  - If size == 0: go straight to DONE; done[c]=1 the next cycle and no write is issued.
  - start[c] while BUSY is ignored: no relatch, no effect on the count.
- Arbitration, evaluated each cycle over eligible channels (BUSY and src_valid):
  - Grant the first eligible channel searching upward from pointer and wrapping. At most one src_ready bit is high.
  - After a grant, pointer = granted index + 1 mod NUM_CH. With no grant, the pointer holds.
  - src_ready depends only on registered state and src_valid; there is no path from src_data.
- Write, 1-cycle latency: a grant at edge t produces mem_we=1 in the cycle after t, with mem_wr_addr = the channel's current address, mem_wr_data = the granted src_data, and mem_wr_ch = c. With no grant, mem_we=0 and addr/data/ch hold their last values.
- Address increments mod 2^ADDR_W per granted word. Example: start at 14, size 4 writes to 14, 15, 0, 1.
- Remaining count decrements per grant. The grant that takes the count 1 -> 0 moves the channel to DONE: busy drops and done rises in the same cycle that mem_we shows the last word.
- Back-to-back: start[c] in the cycle done[c] first reads high is accepted.
- Simultaneous starts on several channels are all accepted in the same cycle.
- Channels are independent. A stalled source (src_valid=0) stalls only its own channel.

Optional Feature:
Macro DMA_CHANNEL_ABORT_EN.
- Defined: adds input abort [NUM_CH].
  - abort[c] while BUSY: channel goes to IDLE next cycle with busy=0 and done=0. The abort takes priority over a grant to c that cycle, so src_ready[c]=0 and nothing is written.
  - abort in IDLE or DONE has no effect.
  - abort and start in the same cycle: abort wins if BUSY, otherwise start is accepted.
- Not defined: the abort port does not exist and channels run only to completion or reset.

Test Plan:
- Single channel: NUM_CH=2; ch0 start_address=0, size=16; src_valid held high with data = 0x10+i -> 16 consecutive mem_we cycles writing mem[i]=0x10+i; busy0 then falls; done0=1 on the 16th write; ch1 never written.
- Wrap: ch1 start_address=14, size=4, data 0xA0..0xA3 -> writes to addresses 14, 15, 0, 1 in order; done1=1.
- Contention: both channels started in the same cycle, size 3 each, sources always valid -> writes alternate ch0, ch1, ch0, ch1, ch0, ch1 (mem_wr_ch 0, 1, 0, 1, 0, 1); both done by the 6th write.
- Zero length and start while busy: size=0 -> done=1 next cycle with no mem_we; a second start while BUSY with size=16 does not change the remaining write count.
- Stall and reset: ch0 size=8 with src_valid toggled at 50% -> exactly 8 writes. A repeat run with rst=1 after the 3rd write -> no further mem_we, all outputs 0, and a fresh start afterwards works.
- With DMA_CHANNEL_ABORT_EN: abort ch0 after 5 of 10 writes -> busy0=0 and done0=0 next cycle with no 6th write; ch1 in progress is unaffected.
